// File: rtl/game_ctrl_if.sv
// game_ctrl_if: groups the game sequencer's pulse inputs and its registered
// outputs. The slave modport is the sequencer's view; the master modport is
// the view of whatever drives the buttons/evaluator/comparator pulses.
interface game_ctrl_if #(
    parameter int PAY_W = 8
);
    logic             start_btn;
    logic             eval_valid;
    logic             hand_win;
    logic [3:0]       win_mult;
    logic             double_btn;
    logic             stop_btn;
    logic             guess_valid;
    logic             guess_high;
    logic             cmp_valid;
    logic             cmp_win;
    logic             cmp_tie;
    logic [1:0]       game_s;
    logic [1:0]       d_count;
    logic             dchance1;
    logic             dchance2;
    logic             guess_q;
    logic [PAY_W-1:0] payout;
    logic             round_over;
    logic             busy;

    modport master (
        output start_btn, eval_valid, hand_win, win_mult, double_btn, stop_btn,
               guess_valid, guess_high, cmp_valid, cmp_win, cmp_tie,
        input  game_s, d_count, dchance1, dchance2, guess_q, payout,
               round_over, busy
    );

    modport slave (
        input  start_btn, eval_valid, hand_win, win_mult, double_btn, stop_btn,
               guess_valid, guess_high, cmp_valid, cmp_win, cmp_tie,
        output game_s, d_count, dchance1, dchance2, guess_q, payout,
               round_over, busy
    );
endinterface

// File: rtl/game_ctrl.sv
// game_ctrl: top-level game sequencer for the poker card datapath. Steps a
// game through deal, hand evaluation and up to MAX_DOUBLE double-up rounds,
// drives the card generator control (game_s, d_count, draw strobes) and keeps
// the running payout. Every output is a register loaded from next-state values.
module game_ctrl #(
    parameter logic [3:0] BET        = 4'd1,
    parameter logic [1:0] MAX_DOUBLE = 2'd3,
    parameter int         PAY_W      = 8
) (
    input  logic       clock,
    input  logic       reset_c,
    game_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAL  = 3'd1,
        ST_EVAL  = 3'd2,
        ST_OFFER = 3'd3,
        ST_DRAW  = 3'd4,
        ST_GUESS = 3'd5,
        ST_CMP   = 3'd6,
        ST_END   = 3'd7
    } state_t;

    localparam logic [PAY_W-1:0] PAY_MAX  = {PAY_W{1'b1}};
    localparam logic [PAY_W-1:0] PAY_ZERO = {PAY_W{1'b0}};

    // Stake times multiplier, clamped to the payout register's range.
    function automatic logic [PAY_W-1:0] sat_mult(input logic [3:0] a, input logic [3:0] b);
        logic [7:0]       prod;
        logic [PAY_W+7:0] wide;
        prod = {4'd0, a} * {4'd0, b};
        wide = {{PAY_W{1'b0}}, prod};
        if (wide > {8'd0, PAY_MAX}) begin
            sat_mult = PAY_MAX;
        end else begin
            sat_mult = wide[PAY_W-1:0];
        end
    endfunction

    // Doubling overflows exactly when the top bit is already set; clamp then.
    function automatic logic [PAY_W-1:0] sat_dbl(input logic [PAY_W-1:0] p);
        if (p[PAY_W-1]) begin
            sat_dbl = PAY_MAX;
        end else begin
            sat_dbl = {p[PAY_W-2:0], 1'b0};
        end
    endfunction

    // Card generator mode seen by the datapath for each sequencer state.
    function automatic logic [1:0] enc_game_s(input state_t s);
        case (s)
            ST_DEAL:                  enc_game_s = 2'b01;
            ST_DRAW, ST_GUESS, ST_CMP: enc_game_s = 2'b10;
            ST_END:                   enc_game_s = 2'b11;
            default:                  enc_game_s = 2'b00;
        endcase
    endfunction

    state_t           state_r;
    state_t           next_state_s;
    logic [1:0]       game_s_r;
    logic [1:0]       d_count_r;
    logic [1:0]       d_count_nx_s;
    logic [1:0]       d_count_inc_s;
    logic             dchance1_r;
    logic             dchance2_r;
    logic             guess_q_r;
    logic             guess_nx_s;
    logic [PAY_W-1:0] payout_r;
    logic [PAY_W-1:0] payout_nx_s;
    logic             round_over_r;
    logic             busy_r;

    assign d_count_inc_s = d_count_r + 2'd1;

    // Sequencer state register.
    always_ff @(posedge clock) begin
        if (reset_c) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state plus next payout / round count / latched guess.
    always_comb begin
        next_state_s = state_r;
        d_count_nx_s = d_count_r;
        guess_nx_s   = guess_q_r;
        payout_nx_s  = payout_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start_btn) begin
                    next_state_s = ST_DEAL;
                    d_count_nx_s = 2'd0;
                    payout_nx_s  = PAY_ZERO;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DEAL: begin
                next_state_s = ST_EVAL;
                d_count_nx_s = 2'd0;
            end
            ST_EVAL: begin
                if (bus.eval_valid) begin
                    if (bus.hand_win) begin
                        payout_nx_s  = sat_mult(BET, bus.win_mult);
                        next_state_s = ST_OFFER;
                    end else begin
                        payout_nx_s  = PAY_ZERO;
                        next_state_s = ST_END;
                    end
                end else begin
                    next_state_s = ST_EVAL;
                end
            end
            ST_OFFER: begin
                // Banking takes priority over a simultaneous double-up request.
                if (bus.stop_btn) begin
                    next_state_s = ST_END;
                end else if (bus.double_btn) begin
                    next_state_s = ST_DRAW;
                end else begin
                    next_state_s = ST_OFFER;
                end
            end
            ST_DRAW: begin
                next_state_s = ST_GUESS;
            end
            ST_GUESS: begin
                if (bus.guess_valid) begin
                    guess_nx_s   = bus.guess_high;
                    next_state_s = ST_CMP;
                end else begin
                    next_state_s = ST_GUESS;
                end
            end
            ST_CMP: begin
                if (bus.cmp_valid) begin
                    if (bus.cmp_tie) begin
                        next_state_s = ST_OFFER;
                    end else if (bus.cmp_win) begin
                        payout_nx_s = sat_dbl(payout_r);
                        // The final round keeps d_count at its last value.
                        if (d_count_inc_s == MAX_DOUBLE) begin
                            next_state_s = ST_END;
                        end else begin
                            d_count_nx_s = d_count_inc_s;
                            next_state_s = ST_OFFER;
                        end
                    end else begin
                        payout_nx_s  = PAY_ZERO;
                        next_state_s = ST_END;
                    end
                end else begin
                    next_state_s = ST_CMP;
                end
            end
            ST_END: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output registers, loaded with the values belonging to the next state.
    always_ff @(posedge clock) begin
        if (reset_c) begin
            game_s_r     <= 2'b00;
            d_count_r    <= 2'd0;
            dchance1_r   <= 1'b0;
            dchance2_r   <= 1'b0;
            guess_q_r    <= 1'b0;
            payout_r     <= PAY_ZERO;
            round_over_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            game_s_r     <= enc_game_s(next_state_s);
            d_count_r    <= d_count_nx_s;
            dchance1_r   <= (next_state_s == ST_DRAW) && (d_count_nx_s == 2'd0);
            dchance2_r   <= (next_state_s == ST_DRAW) && (d_count_nx_s != 2'd0);
            guess_q_r    <= guess_nx_s;
            payout_r     <= payout_nx_s;
            round_over_r <= (next_state_s == ST_END);
            busy_r       <= (next_state_s != ST_IDLE);
        end
    end

    assign bus.game_s     = game_s_r;
    assign bus.d_count    = d_count_r;
    assign bus.dchance1   = dchance1_r;
    assign bus.dchance2   = dchance2_r;
    assign bus.guess_q    = guess_q_r;
    assign bus.payout     = payout_r;
    assign bus.round_over = round_over_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_game_ctrl.sv
// tb_game_ctrl: two sequencers (BET=1 and BET=15) share one stimulus stream.
// A game-level reference model per instance is compared every cycle; a vector
// table and a few directed sequences pin down the documented scenarios.
module tb_game_ctrl;

    localparam int PMAX = 255;
    localparam int MAXD = 3;

    logic clock;
    logic reset_c;
    int   tests;
    int   fails;

    game_ctrl_if #(.PAY_W(8)) bus_a ();
    game_ctrl_if #(.PAY_W(8)) bus_b ();

    assign bus_b.start_btn   = bus_a.start_btn;
    assign bus_b.eval_valid  = bus_a.eval_valid;
    assign bus_b.hand_win    = bus_a.hand_win;
    assign bus_b.win_mult    = bus_a.win_mult;
    assign bus_b.double_btn  = bus_a.double_btn;
    assign bus_b.stop_btn    = bus_a.stop_btn;
    assign bus_b.guess_valid = bus_a.guess_valid;
    assign bus_b.guess_high  = bus_a.guess_high;
    assign bus_b.cmp_valid   = bus_a.cmp_valid;
    assign bus_b.cmp_win     = bus_a.cmp_win;
    assign bus_b.cmp_tie     = bus_a.cmp_tie;

    game_ctrl #(.BET(4'd1), .MAX_DOUBLE(2'd3), .PAY_W(8)) dut_a (
        .clock(clock), .reset_c(reset_c), .bus(bus_a)
    );
    game_ctrl #(.BET(4'd15), .MAX_DOUBLE(2'd3), .PAY_W(8)) dut_b (
        .clock(clock), .reset_c(reset_c), .bus(bus_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- reference model (one per instance) ----------------
    typedef enum int {P_IDLE, P_DEAL, P_EVAL, P_OFFER, P_DRAW, P_GUESS, P_CMP, P_END} phase_t;
    phase_t m_ph   [2];
    int     m_pay  [2];
    int     m_wins [2];
    int     m_gq   [2];
    int     m_bet  [2] = '{1, 15};

    function automatic int clamp(input int v);
        return (v > PMAX) ? PMAX : v;
    endfunction

    task automatic model_step(input int k);
        if (reset_c) begin
            m_ph[k] = P_IDLE; m_pay[k] = 0; m_wins[k] = 0; m_gq[k] = 0;
        end else begin
            case (m_ph[k])
                P_IDLE:  if (bus_a.start_btn) begin m_ph[k] = P_DEAL; m_pay[k] = 0; m_wins[k] = 0; end
                P_DEAL:  m_ph[k] = P_EVAL;
                P_EVAL:  if (bus_a.eval_valid) begin
                             if (bus_a.hand_win) begin
                                 m_pay[k] = clamp(m_bet[k] * int'(bus_a.win_mult)); m_ph[k] = P_OFFER;
                             end else begin
                                 m_pay[k] = 0; m_ph[k] = P_END;
                             end
                         end
                P_OFFER: if (bus_a.stop_btn) m_ph[k] = P_END;
                         else if (bus_a.double_btn) m_ph[k] = P_DRAW;
                P_DRAW:  m_ph[k] = P_GUESS;
                P_GUESS: if (bus_a.guess_valid) begin m_gq[k] = int'(bus_a.guess_high); m_ph[k] = P_CMP; end
                P_CMP:   if (bus_a.cmp_valid) begin
                             if (bus_a.cmp_tie) m_ph[k] = P_OFFER;
                             else if (bus_a.cmp_win) begin
                                 m_pay[k] = clamp(m_pay[k] * 2);
                                 m_wins[k]++;
                                 m_ph[k] = (m_wins[k] == MAXD) ? P_END : P_OFFER;
                             end else begin
                                 m_pay[k] = 0; m_ph[k] = P_END;
                             end
                         end
                default: m_ph[k] = P_IDLE;
            endcase
        end
    endtask

    function automatic int exp_game_s(input int k);
        case (m_ph[k])
            P_DEAL:                return 1;
            P_DRAW, P_GUESS, P_CMP: return 2;
            P_END:                 return 3;
            default:               return 0;
        endcase
    endfunction

    task automatic cmp_val(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input int k, input logic [1:0] gs, input logic [1:0] dc,
                             input logic d1, input logic d2, input logic gq,
                             input logic [7:0] pay, input logic ro, input logic busy);
        int dce;
        dce = (m_wins[k] > MAXD - 1) ? MAXD - 1 : m_wins[k];
        cmp_val($sformatf("dut%0d game_s", k), int'(gs), exp_game_s(k));
        cmp_val($sformatf("dut%0d d_count", k), int'(dc), dce);
        cmp_val($sformatf("dut%0d dchance1", k), int'(d1), int'(m_ph[k] == P_DRAW && m_wins[k] == 0));
        cmp_val($sformatf("dut%0d dchance2", k), int'(d2), int'(m_ph[k] == P_DRAW && m_wins[k] != 0));
        cmp_val($sformatf("dut%0d guess_q", k), int'(gq), m_gq[k]);
        cmp_val($sformatf("dut%0d payout", k), int'(pay), m_pay[k]);
        cmp_val($sformatf("dut%0d round_over", k), int'(ro), int'(m_ph[k] == P_END));
        cmp_val($sformatf("dut%0d busy", k), int'(busy), int'(m_ph[k] != P_IDLE));
    endtask

    task automatic clear_inputs();
        reset_c = 1'b0;
        bus_a.start_btn = 1'b0; bus_a.eval_valid = 1'b0; bus_a.hand_win = 1'b0;
        bus_a.win_mult = 4'd0; bus_a.double_btn = 1'b0; bus_a.stop_btn = 1'b0;
        bus_a.guess_valid = 1'b0; bus_a.guess_high = 1'b0; bus_a.cmp_valid = 1'b0;
        bus_a.cmp_win = 1'b0; bus_a.cmp_tie = 1'b0;
    endtask

    // One clock: model advances on the same inputs, outputs checked 1ns later.
    task automatic tick();
        @(posedge clock);
        model_step(0);
        model_step(1);
        #1;
        check_dut(0, bus_a.game_s, bus_a.d_count, bus_a.dchance1, bus_a.dchance2,
                  bus_a.guess_q, bus_a.payout, bus_a.round_over, bus_a.busy);
        check_dut(1, bus_b.game_s, bus_b.d_count, bus_b.dchance1, bus_b.dchance2,
                  bus_b.guess_q, bus_b.payout, bus_b.round_over, bus_b.busy);
        clear_inputs();
    endtask

    task automatic do_idle();                 tick(); endtask
    task automatic do_start();                bus_a.start_btn = 1'b1; tick(); endtask
    task automatic do_double();               bus_a.double_btn = 1'b1; tick(); endtask
    task automatic do_stop();                 bus_a.stop_btn = 1'b1; tick(); endtask
    task automatic do_guess(input logic gh);  bus_a.guess_valid = 1'b1; bus_a.guess_high = gh; tick(); endtask
    task automatic do_eval(input logic hw, input logic [3:0] m);
        bus_a.eval_valid = 1'b1; bus_a.hand_win = hw; bus_a.win_mult = m; tick();
    endtask
    task automatic do_cmp(input logic w, input logic t);
        bus_a.cmp_valid = 1'b1; bus_a.cmp_win = w; bus_a.cmp_tie = t; tick();
    endtask

    // ---------------- vector table (BET=1 instance) ----------------
    typedef struct {
        logic st; logic ev; logic hw; logic [3:0] mult; logic dbl; logic stp;
        logic gv; logic gh; logic cv; logic cw; logic ct;
        logic [1:0] gs; logic [1:0] dc; logic d1; logic d2; int pay; logic ro; logic busy;
    } vec_t;

    vec_t tv [20];

    initial begin
        tests = 0;
        fails = 0;
        clear_inputs();
        //          st    ev    hw    mult  dbl   stp   gv    gh    cv    cw    ct    gs    dc    d1    d2   pay ro    busy
        tv[0]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tv[1]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 4, 1'b0, 1'b1};
        tv[3]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 4, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 4, 1'b0, 1'b1};
        tv[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 4, 1'b0, 1'b1};
        tv[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0, 1'b0, 8, 1'b0, 1'b1};
        tv[7]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b1, 8, 1'b0, 1'b1};
        tv[8]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 8, 1'b0, 1'b1};
        tv[9]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 1'b0, 1'b0, 8, 1'b0, 1'b1};
        tv[10] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 16, 1'b0, 1'b1};
        tv[11] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b1, 16, 1'b0, 1'b1};
        tv[12] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 16, 1'b0, 1'b1};
        tv[13] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 16, 1'b0, 1'b1};
        tv[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd3, 2'd2, 1'b0, 1'b0, 32, 1'b1, 1'b1};
        tv[15] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0, 32, 1'b0, 1'b0};
        tv[16] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tv[17] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 1'b1};
        tv[18] = '{1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 0, 1'b1, 1'b1};
        tv[19] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 0, 1'b0, 1'b0};

        // Reset state
        #2;
        reset_c = 1'b1; tick();
        reset_c = 1'b1; tick();
        cmp_val("reset game_s", int'(bus_a.game_s), 0);
        cmp_val("reset payout", int'(bus_a.payout), 0);
        cmp_val("reset busy", int'(bus_a.busy), 0);

        // Triple double-up win, then a losing hand
        for (int i = 0; i < 20; i++) begin
            bus_a.start_btn = tv[i].st; bus_a.eval_valid = tv[i].ev; bus_a.hand_win = tv[i].hw;
            bus_a.win_mult = tv[i].mult; bus_a.double_btn = tv[i].dbl; bus_a.stop_btn = tv[i].stp;
            bus_a.guess_valid = tv[i].gv; bus_a.guess_high = tv[i].gh; bus_a.cmp_valid = tv[i].cv;
            bus_a.cmp_win = tv[i].cw; bus_a.cmp_tie = tv[i].ct;
            tick();
            cmp_val($sformatf("vec%0d game_s", i), int'(bus_a.game_s), int'(tv[i].gs));
            cmp_val($sformatf("vec%0d d_count", i), int'(bus_a.d_count), int'(tv[i].dc));
            cmp_val($sformatf("vec%0d dchance1", i), int'(bus_a.dchance1), int'(tv[i].d1));
            cmp_val($sformatf("vec%0d dchance2", i), int'(bus_a.dchance2), int'(tv[i].d2));
            cmp_val($sformatf("vec%0d payout", i), int'(bus_a.payout), tv[i].pay);
            cmp_val($sformatf("vec%0d round_over", i), int'(bus_a.round_over), int'(tv[i].ro));
            cmp_val($sformatf("vec%0d busy", i), int'(bus_a.busy), int'(tv[i].busy));
        end

        // Reset in CMP with cmp_valid high
        do_start(); do_idle(); do_eval(1'b1, 4'd3); do_double(); do_idle(); do_guess(1'b1);
        cmp_val("pre-reset game_s", int'(bus_a.game_s), 2);
        reset_c = 1'b1; bus_a.cmp_valid = 1'b1; bus_a.cmp_win = 1'b1; tick();
        cmp_val("rst-cmp game_s", int'(bus_a.game_s), 0);
        cmp_val("rst-cmp payout", int'(bus_a.payout), 0);
        cmp_val("rst-cmp round_over", int'(bus_a.round_over), 0);
        do_idle();
        cmp_val("post-rst round_over", int'(bus_a.round_over), 0);
        cmp_val("post-rst busy", int'(bus_a.busy), 0);

        // Tie redraws at the same round, then a win; BET=15 saturates
        do_start(); do_idle(); do_eval(1'b1, 4'd2);
        cmp_val("tie payout0", int'(bus_a.payout), 2);
        do_double();
        cmp_val("tie draw1 dchance1", int'(bus_a.dchance1), 1);
        do_idle(); do_guess(1'b0); do_cmp(1'b1, 1'b1);
        cmp_val("tie payout", int'(bus_a.payout), 2);
        cmp_val("tie d_count", int'(bus_a.d_count), 0);
        do_double();
        cmp_val("tie draw2 dchance1", int'(bus_a.dchance1), 1);
        do_idle(); do_guess(1'b1); do_cmp(1'b1, 1'b0);
        cmp_val("tie-win payout", int'(bus_a.payout), 4);
        cmp_val("tie-win d_count", int'(bus_a.d_count), 1);
        do_stop(); do_idle();

        do_start(); do_idle(); do_eval(1'b1, 4'd15);
        cmp_val("bet15 payout", int'(bus_b.payout), 225);
        do_double(); do_idle(); do_guess(1'b1); do_cmp(1'b1, 1'b0);
        cmp_val("bet15 sat payout", int'(bus_b.payout), 255);
        do_stop(); do_idle();

        // Double and stop together bank; start during GUESS is ignored
        do_start(); do_idle(); do_eval(1'b1, 4'd1);
        bus_a.double_btn = 1'b1; bus_a.stop_btn = 1'b1; tick();
        cmp_val("dbl+stop game_s", int'(bus_a.game_s), 3);
        cmp_val("dbl+stop dchance1", int'(bus_a.dchance1), 0);
        do_idle();
        do_start(); do_idle(); do_eval(1'b1, 4'd5); do_double(); do_idle();
        do_start();
        cmp_val("start-in-guess game_s", int'(bus_a.game_s), 2);
        cmp_val("start-in-guess payout", int'(bus_a.payout), 5);
        do_guess(1'b0); do_cmp(1'b0, 1'b0);
        cmp_val("lose payout", int'(bus_a.payout), 0);
        do_idle();

        // Randomized play against the model
        for (int i = 0; i < 4000; i++) begin
            reset_c           = ($urandom_range(0, 299) == 0);
            bus_a.start_btn   = ($urandom_range(0, 3) == 0);
            bus_a.eval_valid  = ($urandom_range(0, 2) == 0);
            bus_a.hand_win    = ($urandom_range(0, 3) != 0);
            bus_a.win_mult    = 4'($urandom_range(0, 15));
            bus_a.double_btn  = ($urandom_range(0, 2) == 0);
            bus_a.stop_btn    = ($urandom_range(0, 5) == 0);
            bus_a.guess_valid = ($urandom_range(0, 2) == 0);
            bus_a.guess_high  = 1'($urandom_range(0, 1));
            bus_a.cmp_valid   = ($urandom_range(0, 2) == 0);
            bus_a.cmp_win     = ($urandom_range(0, 3) != 0);
            bus_a.cmp_tie     = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
